// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous memory.
// Data accesses take priority over fetches; lost fetch cycles are counted.
module mem_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter int unsigned CW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic [DW-1:0]   if_rdata,
  output logic            if_valid,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic [DW-1:0]   d_rdata,
  output logic            d_valid,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic [DW-1:0]   mem_rdata,
  output logic [CW-1:0]   contention_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;
  typedef enum logic {OWN_I, OWN_D} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              mem_en_q, mem_we_q;
  logic [AW-1:0]     mem_addr_q;
  logic [DW-1:0]     mem_wdata_q;
  logic [DW/8-1:0]   mem_be_q;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic served_i, served_d, elig_i, elig_d, can_arb, grant_i, grant_d, lost;

  always_comb begin
    // The port in its RESP cycle still has req high and must not be re-granted.
    served_i = (state_q == RESP) && (owner_q == OWN_I);
    served_d = (state_q == RESP) && (owner_q == OWN_D);
    elig_i   = if_req && !served_i;
    elig_d   = d_req && !served_d;
    can_arb  = (state_q != ISSUE);
    grant_d  = can_arb && elig_d;
    grant_i  = can_arb && elig_i && !elig_d;

    state_d = state_q;
    owner_d = owner_q;
    unique case (state_q)
      IDLE, RESP: state_d = (grant_d || grant_i) ? ISSUE : IDLE;
      ISSUE:      state_d = RESP;
      default:    state_d = IDLE;
    endcase
    if (grant_d)      owner_d = OWN_D;
    else if (grant_i) owner_d = OWN_I;

    lost  = if_req && (((state_q != IDLE) && (owner_q == OWN_D)) ||
                       ((state_q == IDLE) && grant_d));
    cnt_d = (lost && (cnt_q != '1)) ? cnt_q + CW'(1) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_I;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      mem_en_q <= grant_d || grant_i;
      mem_we_q <= 1'b0;
      if (grant_d) begin
        mem_we_q    <= d_we;
        mem_addr_q  <= d_addr;
        mem_wdata_q <= d_wdata;
        mem_be_q    <= d_we ? d_be : '1;
      end else if (grant_i) begin
        mem_addr_q  <= if_addr;
        mem_be_q    <= '1;
      end
    end
  end

  assign if_valid       = (state_q == RESP) && (owner_q == OWN_I);
  assign d_valid        = (state_q == RESP) && (owner_q == OWN_D);
  assign if_rdata       = mem_rdata;
  assign d_rdata        = mem_rdata;
  assign mem_en         = mem_en_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign mem_be         = mem_be_q;
  assign contention_cnt = cnt_q;

endmodule
